serial_mag_comp: RTL and testbench
==================================

# serial_mag_comp

Digit-serial N-bit magnitude comparator controller. It captures two WIDTH-bit operands and walks them MSB-first in 2-bit slices. Each slice drives the team's 2-bit comparator, and the block consumes that comparator's higher/lower/same outputs on the next edge. The block sits directly around the 2-bit comparator: it is both the upstream feeder and the downstream consumer. It turns the comparator into a WIDTH-bit comparator with a start/done handshake and early termination.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥ 2.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- start  input  1  request a comparison; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- slice_a  output  [0:1]  current A slice to the comparator; bit 0 is the more significant bit.
- slice_b  output  [0:1]  current B slice, same ordering as slice_a.
- cmp_higher  input  1  comparator: slice_a > slice_b.
- cmp_lower  input  1  comparator: slice_a < slice_b.
- cmp_same  input  1  comparator: slice_a == slice_b.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle.
- a_gt  output  1  result A > B.
- a_lt  output  1  result A < B.
- a_eq  output  1  result A == B.
- err  output  1  comparator returned a non-one-hot response; comparison aborted.

## Operation
- States: IDLE, RUN.
- **IDLE**
  - slice_a/slice_b = 2'b00.
  - On start=1: load a/b into shift registers and clear a_gt/a_lt/a_eq/err to 0.
  - Set slice index to 0 and go to RUN.
- **RUN**
  - slice_a/slice_b are combinational from the top two bits of the shift registers: slice_a[0]=A[WIDTH-1-2k], slice_a[1]=A[WIDTH-2-2k] for slice k.
  - Comparator response is sampled each RUN edge and evaluated in priority order:
    - Not exactly one of cmp_higher/cmp_lower/cmp_same high: err=1, done=1, results stay 0, go to IDLE.
    - cmp_higher: a_gt=1, done=1, go to IDLE (early exit).
    - cmp_lower: a_lt=1, done=1, go to IDLE (early exit).
    - cmp_same and k = WIDTH/2-1: a_eq=1, done=1, go to IDLE.
    - cmp_same otherwise: shift both registers left by 2, k+1, stay in RUN.
- Slice counter width is ceil(log2(WIDTH/2)), minimum 1. It never wraps because the last slice always exits.
- start while busy is ignored. Operands are not re-sampled.
- a_gt/a_lt/a_eq/err hold after done until the next accepted start. At most one of the four is ever high.
- busy = (state == RUN).

## Timing
- Reset (rst_n=0 at an edge) sets:
  - state IDLE
  - busy, done, a_gt, a_lt, a_eq, err all 0
  - shift registers 0, so slice_a/slice_b are 2'b00
- Reset mid-RUN aborts the comparison with no done pulse and takes priority over every other event.
- Start accepted at edge E0. RUN slice k is presented in cycle E0+k+1 and sampled at edge E0+k+1.
- Latency is edge E0 to done high:
  - d cycles when slice d-1 decides.
  - Range 1 to WIDTH/2 cycles.
- done is high for exactly one cycle, and in that cycle the state is already IDLE.
  - start=1 in the done cycle is accepted: back-to-back comparisons with zero idle cycles.
  - Results clear on that edge.
- The comparator path is combinational: slice outputs come from registers, and the comparator result is sampled on the same cycle.

## Test plan
- WIDTH=8, a=0xA5, b=0xA5, start pulsed → busy high for 4 cycles; slices presented 10/10, 10/10, 01/01, 01/01; done at edge E0+4 with a_eq=1, a_gt=a_lt=err=0.
- a=0x80, b=0x7F → first slice 10 vs 01 gives cmp_higher; done at E0+1 with a_gt=1; busy high for 1 cycle only.
- a=0x3C, b=0x3D → slices equal until the last (00 vs 01); done at E0+4 with a_lt=1.
- Start held high through RUN (a=0x00, b=0x00), new a/b changed mid-run → result a_eq=1 for the original operands. Start=1 in the done cycle with a=0xFF, b=0x00 → accepted, then a_gt=1 at the next done one cycle later.
- rst_n=0 during the second RUN cycle of a=0x12 vs b=0x13 → next edge: busy=0, slices 00/00, all results 0, no done pulse; a fresh start then completes normally.
- Comparator model forced to all-zero response on slice 1 → done at E0+2 with err=1, a_gt=a_lt=a_eq=0. Forcing cmp_higher=cmp_same=1 gives the same err result.

Source files
------------

// File: rtl/serial_mag_comp.sv
// Digit-serial WIDTH-bit magnitude comparator: walks both operands MSB-first in
// 2-bit slices through an external 2-bit comparator, with early exit.
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [0:1]       slice_a,
  output logic [0:1]       slice_b,
  input  logic             cmp_higher,
  input  logic             cmp_lower,
  input  logic             cmp_same,
  output logic             busy,
  output logic             done,
  output logic             a_gt,
  output logic             a_lt,
  output logic             a_eq,
  output logic             err
);

  localparam int SLICES = WIDTH / 2;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(SLICES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             done_q, done_d;
  logic             a_gt_q, a_gt_d, a_lt_q, a_lt_d, a_eq_q, a_eq_d, err_q, err_d;
  logic             resp_onehot;

  assign resp_onehot = ({cmp_higher, cmp_lower, cmp_same} == 3'b100) ||
                       ({cmp_higher, cmp_lower, cmp_same} == 3'b010) ||
                       ({cmp_higher, cmp_lower, cmp_same} == 3'b001);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    a_gt_d  = a_gt_q;
    a_lt_d  = a_lt_q;
    a_eq_d  = a_eq_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          idx_d   = '0;
          a_gt_d  = 1'b0;
          a_lt_d  = 1'b0;
          a_eq_d  = 1'b0;
          err_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // A malformed comparator response aborts before any result is trusted.
        if (!resp_onehot) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cmp_higher) begin
          a_gt_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cmp_lower) begin
          a_lt_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == LAST_IDX) begin
          a_eq_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          a_sh_d  = a_sh_q << 2;
          b_sh_d  = b_sh_q << 2;
          idx_d   = idx_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      a_gt_q  <= 1'b0;
      a_lt_q  <= 1'b0;
      a_eq_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      a_gt_q  <= a_gt_d;
      a_lt_q  <= a_lt_d;
      a_eq_q  <= a_eq_d;
      err_q   <= err_d;
    end
  end

  // Slices only leave 00 while running; leftover shift contents stay hidden in IDLE.
  always_comb begin
    slice_a = 2'b00;
    slice_b = 2'b00;
    if (state_q == RUN) begin
      slice_a[0] = a_sh_q[WIDTH-1];
      slice_a[1] = a_sh_q[WIDTH-2];
      slice_b[0] = b_sh_q[WIDTH-1];
      slice_b[1] = b_sh_q[WIDTH-2];
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign a_gt = a_gt_q;
  assign a_lt = a_lt_q;
  assign a_eq = a_eq_q;
  assign err  = err_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed bench for serial_mag_comp with a behavioural 2-bit comparator model
// that can be made to return malformed responses.
module tb_serial_mag_comp;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [7:0] a_in, b_in;
  logic [0:1] slice_a, slice_b;
  logic       cmp_higher, cmp_lower, cmp_same;
  logic       busy, done, a_gt, a_lt, a_eq, err;
  int         fault_mode;  // 0 normal, 1 all-zero, 2 higher+same

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  serial_mag_comp #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a_in), .b(b_in),
    .slice_a(slice_a), .slice_b(slice_b),
    .cmp_higher(cmp_higher), .cmp_lower(cmp_lower), .cmp_same(cmp_same),
    .busy(busy), .done(done), .a_gt(a_gt), .a_lt(a_lt), .a_eq(a_eq), .err(err)
  );

  logic [1:0] sa, sb;
  always_comb begin
    sa = {slice_a[0], slice_a[1]};
    sb = {slice_b[0], slice_b[1]};
    cmp_higher = (sa > sb);
    cmp_lower  = (sa < sb);
    cmp_same   = (sa == sb);
    if (fault_mode == 1) begin
      cmp_higher = 1'b0; cmp_lower = 1'b0; cmp_same = 1'b0;
    end else if (fault_mode == 2) begin
      cmp_higher = 1'b1; cmp_lower = 1'b0; cmp_same = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // results packed as {gt, lt, eq, err}
  task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input int exp_lat, input logic [3:0] exp_res,
                         input int fault_k, input int fmode);
    int lat;
    logic [1:0] ea, eb;
    lat = 0;
    @(negedge clk);
    start = 1'b1; a_in = av; b_in = bv;
    @(negedge clk);
    start = 1'b0; a_in = ~av; b_in = ~bv;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      fault_mode = (c - 1 == fault_k) ? fmode : 0;
      ea = 2'((av >> (8 - 2 * c)) & 8'h3);
      eb = 2'((bv >> (8 - 2 * c)) & 8'h3);
      check($sformatf("%s busy k%0d", tag, c - 1), busy, 1);
      check($sformatf("%s slices k%0d", tag, c - 1), {sa, sb}, {ea, eb});
      @(negedge clk);
      if (done) lat = c;
    end
    fault_mode = 0;
    check($sformatf("%s latency", tag), lat, exp_lat);
    check($sformatf("%s result", tag), {a_gt, a_lt, a_eq, err}, exp_res);
    check($sformatf("%s idle at done", tag), busy, 0);
    @(negedge clk);
    check($sformatf("%s done pulse", tag), done, 0);
    check($sformatf("%s result hold", tag), {a_gt, a_lt, a_eq, err}, exp_res);
    $display("txn %s a=%02h b=%02h lat=%0d res=%04b", tag, av, bv, lat, {a_gt, a_lt, a_eq, err});
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; a_in = 8'h00; b_in = 8'h00; fault_mode = 0;
    repeat (2) @(negedge clk);
    check("reset outputs", {busy, done, a_gt, a_lt, a_eq, err}, 6'b0);
    check("reset slices", {sa, sb}, 4'b0);
    rst_n = 1'b1;

    run_cmp("eq_a5", 8'hA5, 8'hA5, 4, 4'b0010, -1, 0);
    run_cmp("gt_80_7f", 8'h80, 8'h7F, 1, 4'b1000, -1, 0);
    run_cmp("lt_3c_3d", 8'h3C, 8'h3D, 4, 4'b0100, -1, 0);
    run_cmp("err_zero", 8'h11, 8'h11, 2, 4'b0001, 1, 1);
    run_cmp("err_hs", 8'h11, 8'h11, 2, 4'b0001, 1, 2);

    // start held through RUN with operands changing; then back-to-back start
    @(negedge clk);
    start = 1'b1; a_in = 8'h00; b_in = 8'h00;
    @(negedge clk);
    a_in = 8'h55; b_in = 8'hAA;
    lat = 0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (done) lat = c;
    end
    check("held latency", lat, 4);
    check("held result", {a_gt, a_lt, a_eq, err}, 4'b0010);
    $display("txn held a=00 b=00 lat=%0d res=%04b", lat, {a_gt, a_lt, a_eq, err});
    a_in = 8'hFF; b_in = 8'h00;
    @(negedge clk);
    start = 1'b0;
    check("b2b accepted", busy, 1);
    check("b2b cleared", {a_gt, a_lt, a_eq, err}, 4'b0000);
    check("b2b slices", {sa, sb}, 4'b1100);
    @(negedge clk);
    check("b2b done", done, 1);
    check("b2b result", {a_gt, a_lt, a_eq, err}, 4'b1000);
    $display("txn b2b a=ff b=00 done=%0b res=%04b", done, {a_gt, a_lt, a_eq, err});

    // reset during the second RUN cycle
    @(negedge clk);
    start = 1'b1; a_in = 8'h12; b_in = 8'h13;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre-reset busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid reset outputs", {busy, done, a_gt, a_lt, a_eq, err}, 6'b0);
    check("mid reset slices", {sa, sb}, 4'b0);
    @(negedge clk);
    check("mid reset no done", done, 0);
    $display("txn reset a=12 b=13 busy=%0b done=%0b", busy, done);
    run_cmp("lt_12_13", 8'h12, 8'h13, 4, 4'b0100, -1, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
